// File: rtl/axi_apb_bridge_ms.sv
// AXI4-lite slave to multi-slave APB bridge, one outstanding transaction, round-robin read/write grant.
// Optional ACCESS-phase abort counter enabled by defining AXI_APB_BRIDGE_TIMEOUT_EN.
module axi_apb_bridge_ms #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int NUM_SLV     = 4,
    parameter int SEL_LSB     = 12,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic [ADDR_W-1:0]         awaddr,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [DATA_W-1:0]         wdata,
    input  logic [DATA_W/8-1:0]       wstrb,
    input  logic                      wvalid,
    output logic                      wready,
    output logic [1:0]                bresp,
    output logic                      bvalid,
    input  logic                      bready,
    input  logic [ADDR_W-1:0]         araddr,
    input  logic                      arvalid,
    output logic                      arready,
    output logic [DATA_W-1:0]         rdata,
    output logic [1:0]                rresp,
    output logic                      rvalid,
    input  logic                      rready,
    output logic [NUM_SLV-1:0]        PSEL,
    output logic                      PENABLE,
    output logic                      PWRITE,
    output logic [ADDR_W-1:0]         PADDR,
    output logic [DATA_W-1:0]         PWDATA,
    output logic [DATA_W/8-1:0]       PSTRB,
    input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
    input  logic [NUM_SLV-1:0]        PREADY,
    input  logic [NUM_SLV-1:0]        PSLVERR,
    output logic [2:0]                state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ACCESS = 3'd2,
        WRESP  = 3'd3,
        RRESP  = 3'd4
    } state_t;

    state_t              st;
    logic                rd_prio;
    logic                wr_req, rd_req, wr_grant, rd_grant;
    logic [3:0]          aw_idx, ar_idx;
    logic                sel_ready, sel_err, acc_done, acc_err;
    logic [DATA_W-1:0]   sel_rdata;

`ifdef AXI_APB_BRIDGE_TIMEOUT_EN
    localparam int TCNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [TCNT_W-1:0]   tcnt;
`endif

    function automatic logic [1:0] resp_code(input logic err);
        return err ? 2'b10 : 2'b00;
    endfunction

    function automatic logic in_range(input logic [3:0] idx);
        return {1'b0, idx} < 5'(NUM_SLV);
    endfunction

    function automatic logic [NUM_SLV-1:0] decode(input logic [3:0] idx);
        logic [NUM_SLV-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (idx == 4'(i)) oh[i] = 1'b1;
        end
        return oh;
    endfunction

    assign aw_idx = awaddr[SEL_LSB+3:SEL_LSB];
    assign ar_idx = araddr[SEL_LSB+3:SEL_LSB];
    assign state  = st;

    // Ready is a decode of the registered state so the grant lands in the same cycle it is offered.
    assign wr_req   = awvalid && wvalid;
    assign rd_req   = arvalid;
    assign wr_grant = !areset && (st == IDLE) && wr_req && (!rd_req || !rd_prio);
    assign rd_grant = !areset && (st == IDLE) && rd_req && (!wr_req || rd_prio);
    assign awready  = wr_grant;
    assign wready   = wr_grant;
    assign arready  = rd_grant;

    // PSEL is one-hot and registered, so masking with it ignores every unselected slave.
    always_comb begin
        sel_ready = |(PREADY & PSEL);
        sel_err   = |(PSLVERR & PSEL);
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (PSEL[i]) sel_rdata = sel_rdata | PRDATA[i*DATA_W +: DATA_W];
        end
        acc_done  = sel_ready;
        acc_err   = sel_err;
`ifdef AXI_APB_BRIDGE_TIMEOUT_EN
        if (!sel_ready && tcnt == TCNT_W'(TIMEOUT_CYC - 1)) begin
            acc_done = 1'b1;
            acc_err  = 1'b1;
        end
`endif
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            st      <= IDLE;
            rd_prio <= 1'b0;
            PSEL    <= '0;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            PADDR   <= '0;
            PWDATA  <= '0;
            PSTRB   <= '0;
            bvalid  <= 1'b0;
            bresp   <= 2'b00;
            rvalid  <= 1'b0;
            rresp   <= 2'b00;
            rdata   <= '0;
`ifdef AXI_APB_BRIDGE_TIMEOUT_EN
            tcnt    <= '0;
`endif
        end else begin
            case (st)
                IDLE: begin
                    if (wr_grant) begin
                        rd_prio <= 1'b1;
                        if (in_range(aw_idx)) begin
                            st     <= SETUP;
                            PSEL   <= decode(aw_idx);
                            PWRITE <= 1'b1;
                            PADDR  <= awaddr;
                            PWDATA <= wdata;
                            PSTRB  <= wstrb;
                        end else begin
                            st     <= WRESP;
                            bvalid <= 1'b1;
                            bresp  <= 2'b11;
                        end
                    end else if (rd_grant) begin
                        rd_prio <= 1'b0;
                        if (in_range(ar_idx)) begin
                            st     <= SETUP;
                            PSEL   <= decode(ar_idx);
                            PWRITE <= 1'b0;
                            PADDR  <= araddr;
                            PWDATA <= '0;
                            PSTRB  <= '0;
                        end else begin
                            st     <= RRESP;
                            rvalid <= 1'b1;
                            rresp  <= 2'b11;
                            rdata  <= '0;
                        end
                    end
                end
                SETUP: begin
                    st      <= ACCESS;
                    PENABLE <= 1'b1;
`ifdef AXI_APB_BRIDGE_TIMEOUT_EN
                    tcnt    <= '0;
`endif
                end
                ACCESS: begin
                    if (acc_done) begin
                        PSEL    <= '0;
                        PENABLE <= 1'b0;
                        if (PWRITE) begin
                            st     <= WRESP;
                            bvalid <= 1'b1;
                            bresp  <= resp_code(acc_err);
                        end else begin
                            st     <= RRESP;
                            rvalid <= 1'b1;
                            rresp  <= resp_code(acc_err);
                            rdata  <= acc_err ? '0 : sel_rdata;
                        end
                    end
`ifdef AXI_APB_BRIDGE_TIMEOUT_EN
                    else begin
                        tcnt <= tcnt + TCNT_W'(1);
                    end
`endif
                end
                WRESP: begin
                    if (bready) begin
                        bvalid <= 1'b0;
                        st     <= IDLE;
                    end
                end
                RRESP: begin
                    if (rready) begin
                        rvalid <= 1'b0;
                        st     <= IDLE;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_apb_bridge_ms.sv
// Scoreboard bench for axi_apb_bridge_ms: APB transfers and AXI responses are predicted when driven
// and checked when they appear; latency and handshake timing checked by directed steps.
module tb_axi_apb_bridge_ms;

    logic         aclk = 1'b0;
    logic         areset;
    logic [31:0]  awaddr, wdata, araddr, rdata, PADDR, PWDATA;
    logic [3:0]   wstrb, PSTRB, PSEL, PREADY, PSLVERR;
    logic         awvalid, awready, wvalid, wready, bvalid, bready;
    logic         arvalid, arready, rvalid, rready, PENABLE, PWRITE;
    logic [1:0]   bresp, rresp;
    logic [127:0] PRDATA;
    logic [2:0]   state;

    int           n_cmp = 0;
    int           n_err = 0;

    int           wait_cfg = 0;
    logic         err_cfg  = 1'b0;
    logic         hang     = 1'b0;
    logic [31:0]  rdata_cfg = 32'h0;
    int           acc_cnt  = 0;

    typedef struct {
        logic [3:0]  psel;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } apb_t;
    typedef struct {
        logic [1:0]  resp;
        logic [31:0] rdata;
    } resp_t;

    apb_t  exp_apb[$];
    resp_t exp_b[$];
    resp_t exp_r[$];

    axi_apb_bridge_ms dut (
        .aclk(aclk), .areset(areset),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR), .state(state)
    );

    always #5 aclk = ~aclk;

    // Selected slave follows the configured behaviour; unselected slaves shout ready/error/garbage.
    always @(posedge aclk) acc_cnt <= PENABLE ? acc_cnt + 1 : 0;

    always_comb begin
        PREADY  = '0;
        PSLVERR = '0;
        PRDATA  = '0;
        for (int i = 0; i < 4; i++) begin
            if (PSEL[i]) begin
                PREADY[i]          = PENABLE && !hang && (acc_cnt >= wait_cfg);
                PSLVERR[i]         = err_cfg;
                PRDATA[i*32 +: 32] = rdata_cfg;
            end else begin
                PREADY[i]          = 1'b1;
                PSLVERR[i]         = 1'b1;
                PRDATA[i*32 +: 32] = 32'hBAD0_0000 | 32'(i);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge aclk) begin
        if (!areset) begin
            if (PENABLE && |(PSEL & PREADY)) begin
                if (exp_apb.size() == 0) begin
                    chk("apb_unexpected", {31'b0, PENABLE}, 32'd0);
                end else begin
                    apb_t a;
                    a = exp_apb.pop_front();
                    chk("apb_psel", {28'b0, PSEL}, {28'b0, a.psel});
                    chk("apb_pwrite", {31'b0, PWRITE}, {31'b0, a.write});
                    chk("apb_paddr", PADDR, a.addr);
                    chk("apb_pwdata", PWDATA, a.wdata);
                    chk("apb_pstrb", {28'b0, PSTRB}, {28'b0, a.strb});
                end
            end
            if (bvalid && bready) begin
                if (exp_b.size() == 0) begin
                    chk("b_unexpected", {31'b0, bvalid}, 32'd0);
                end else begin
                    resp_t r;
                    r = exp_b.pop_front();
                    chk("bresp", {30'b0, bresp}, {30'b0, r.resp});
                end
            end
            if (rvalid && rready) begin
                if (exp_r.size() == 0) begin
                    chk("r_unexpected", {31'b0, rvalid}, 32'd0);
                end else begin
                    resp_t r;
                    r = exp_r.pop_front();
                    chk("rresp", {30'b0, rresp}, {30'b0, r.resp});
                    chk("rdata", rdata, r.rdata);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    // Reference model: slave index from address bits [15:12], four slaves present.
    task automatic push_exp(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb);
        logic [3:0] idx;
        apb_t       a;
        resp_t      r;
        idx = addr[15:12];
        if (idx < 4'd4) begin
            a.psel  = 4'b0001 << idx;
            a.write = wr;
            a.addr  = addr;
            a.wdata = wr ? data : 32'h0;
            a.strb  = wr ? strb : 4'h0;
            if (!hang) exp_apb.push_back(a);
            r.resp = (err_cfg || hang) ? 2'b10 : 2'b00;
        end else begin
            r.resp = 2'b11;
        end
        r.rdata = (!wr && r.resp == 2'b00) ? rdata_cfg : 32'h0;
        if (wr) exp_b.push_back(r);
        else    exp_r.push_back(r);
    endtask

    task automatic run_txn(input string tag, input logic wr, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] strb, input int exp_lat);
        int lat;
        push_exp(wr, addr, data, strb);
        cyc();
        if (wr) begin
            awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
        end else begin
            araddr = addr; arvalid = 1'b1;
        end
        #1;
        chk({tag, "_grant"}, {31'b0, wr ? awready : arready}, 32'd1);
        cyc();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        lat = 1;
        while (!(wr ? bvalid : rvalid) && lat < 60) begin
            cyc();
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        cyc();
        chk({tag, "_idle"}, {29'b0, state}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        areset = 1'b1;
        awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        bready = 1'b1; rready = 1'b1;
        repeat (3) cyc();
        #1;
        chk("rst_state", {29'b0, state}, 32'd0);
        chk("rst_awready", {31'b0, awready}, 32'd0);
        chk("rst_arready", {31'b0, arready}, 32'd0);
        chk("rst_psel", {28'b0, PSEL}, 32'd0);
        chk("rst_penable", {31'b0, PENABLE}, 32'd0);
        chk("rst_bvalid", {31'b0, bvalid}, 32'd0);
        chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
        chk("rst_paddr", PADDR, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        cyc();
        areset = 1'b0;

        // Zero-wait write to slave 2, stage by stage.
        push_exp(1'b1, 32'h0000_2004, 32'hDEAD_BEEF, 4'hF);
        cyc();
        awaddr = 32'h0000_2004; wdata = 32'hDEAD_BEEF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        #1;
        chk("w1_awready_T", {31'b0, awready}, 32'd1);
        chk("w1_wready_T", {31'b0, wready}, 32'd1);
        chk("w1_arready_T", {31'b0, arready}, 32'd0);
        cyc();
        awvalid = 1'b0; wvalid = 1'b0;
        chk("w1_state_T1", {29'b0, state}, 32'd1);
        chk("w1_psel_T1", {28'b0, PSEL}, 32'b0100);
        chk("w1_penable_T1", {31'b0, PENABLE}, 32'd0);
        chk("w1_awready_T1", {31'b0, awready}, 32'd0);
        cyc();
        chk("w1_state_T2", {29'b0, state}, 32'd2);
        chk("w1_penable_T2", {31'b0, PENABLE}, 32'd1);
        chk("w1_psel_T2", {28'b0, PSEL}, 32'b0100);
        cyc();
        chk("w1_bvalid_T3", {31'b0, bvalid}, 32'd1);
        chk("w1_psel_T3", {28'b0, PSEL}, 32'd0);
        cyc();
        chk("w1_state_T4", {29'b0, state}, 32'd0);
        chk("w1_bvalid_T4", {31'b0, bvalid}, 32'd0);

        // Read slave 1 with three wait states.
        wait_cfg = 3; rdata_cfg = 32'h1234_5678;
        run_txn("r1", 1'b0, 32'h0000_1010, 32'h0, 4'h0, 6);

        // Write, read and write requests all contending: write then read.
        wait_cfg = 1; rdata_cfg = 32'hCAFE_F00D;
        push_exp(1'b1, 32'h0000_3008, 32'h0102_0304, 4'b0101);
        push_exp(1'b0, 32'h0000_2008, 32'h0, 4'h0);
        cyc();
        awaddr = 32'h0000_3008; wdata = 32'h0102_0304; wstrb = 4'b0101;
        araddr = 32'h0000_2008;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        #1;
        chk("rr1_awready", {31'b0, awready}, 32'd1);
        chk("rr1_arready", {31'b0, arready}, 32'd0);
        cyc();
        k = 0;
        while (state != 3'd0 && k < 20) begin
            cyc();
            k++;
        end
        chk("rr_wait_idle", {29'b0, state}, 32'd0);
        chk("rr2_arready", {31'b0, arready}, 32'd1);
        chk("rr2_awready", {31'b0, awready}, 32'd0);
        cyc();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        k = 0;
        while (!rvalid && k < 20) begin
            cyc();
            k++;
        end
        chk("rr2_rvalid", {31'b0, rvalid}, 32'd1);
        cyc();

        // Decode errors: no APB activity, response one cycle after grant.
        wait_cfg = 0; rdata_cfg = 32'h7777_7777;
        run_txn("rdec", 1'b0, 32'h0000_7000, 32'h0, 4'h0, 1);
        run_txn("wdec", 1'b1, 32'h0000_F000, 32'h1111_2222, 4'hF, 1);

        // Slave errors on write and read; read data must be forced to zero.
        err_cfg = 1'b1;
        run_txn("werr", 1'b1, 32'h0000_0040, 32'hA5A5_A5A5, 4'h3, 3);
        rdata_cfg = 32'hFFFF_0000;
        run_txn("rerr", 1'b0, 32'h0000_3000, 32'h0, 4'h0, 3);
        err_cfg = 1'b0;

        // Read response back-pressure with a write pending.
        rdata_cfg = 32'h5555_AAAA;
        rready = 1'b0;
        push_exp(1'b0, 32'h0000_1004, 32'h0, 4'h0);
        cyc();
        araddr = 32'h0000_1004; arvalid = 1'b1;
        #1;
        chk("bp_arready", {31'b0, arready}, 32'd1);
        cyc();
        arvalid = 1'b0;
        k = 0;
        while (!rvalid && k < 20) begin
            cyc();
            k++;
        end
        awaddr = 32'h0000_0000; wdata = 32'h0; wstrb = 4'h0; awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_rvalid_hold", {31'b0, rvalid}, 32'd1);
            chk("bp_rdata_hold", rdata, 32'h5555_AAAA);
            chk("bp_awready_low", {31'b0, awready}, 32'd0);
            cyc();
        end
        rready = 1'b1;
        #1;
        chk("bp_awready_release", {31'b0, awready}, 32'd0);
        cyc();
        awvalid = 1'b0; wvalid = 1'b0;
        chk("bp_state_idle", {29'b0, state}, 32'd0);
        chk("bp_rvalid_done", {31'b0, rvalid}, 32'd0);

`ifdef AXI_APB_BRIDGE_TIMEOUT_EN
        hang = 1'b1;
        run_txn("tmo", 1'b1, 32'h0000_0010, 32'h0BAD_F00D, 4'hF, 18);
        hang = 1'b0;
`endif

        // Reset in the middle of ACCESS abandons the transfer.
        wait_cfg = 10;
        cyc();
        awaddr = 32'h0000_1000; wdata = 32'h9999_9999; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        #1;
        chk("ra_awready", {31'b0, awready}, 32'd1);
        cyc();
        awvalid = 1'b0; wvalid = 1'b0;
        cyc();
        chk("ra_state_access", {29'b0, state}, 32'd2);
        chk("ra_penable", {31'b0, PENABLE}, 32'd1);
        areset = 1'b1;
        cyc();
        chk("ra_psel", {28'b0, PSEL}, 32'd0);
        chk("ra_state", {29'b0, state}, 32'd0);
        chk("ra_penable_off", {31'b0, PENABLE}, 32'd0);
        chk("ra_bvalid", {31'b0, bvalid}, 32'd0);
        areset = 1'b0;
        cyc();
        cyc();
        chk("ra_bvalid_after", {31'b0, bvalid}, 32'd0);
        wait_cfg = 0;

        // Round-robin pointer is write-first again after reset.
        awaddr = 32'h0000_0000; araddr = 32'h0000_0000;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        #1;
        chk("rst_rr_awready", {31'b0, awready}, 32'd1);
        chk("rst_rr_arready", {31'b0, arready}, 32'd0);
        #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        cyc();
        chk("rst_rr_no_grant", {29'b0, state}, 32'd0);

        cyc();
        chk("apb_left", 32'(exp_apb.size()), 32'd0);
        chk("b_left", 32'(exp_b.size()), 32'd0);
        chk("r_left", 32'(exp_r.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
